icache_ctrl: RTL and testbench

Direct-mapped, read-only instruction cache with miss-fill state machine and hit/miss counters. Sits directly upstream of the pipeline IF stage. It serves 16-bit instructions to fetch on hits in the same cycle, and stalls fetch while it refills a 4-word line from main memory over a hold-until-ready handshake.

---
 rtl/icache_ctrl_pkg.sv | 21 ++
 rtl/icache_array.sv | 50 +++++
 rtl/icache_ctrl.sv | 135 +++++++++++++
 tb/tb_icache_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction cache: FSM encodings, geometry
// constants and the word-select helper used on the hit path.
package icache_ctrl_pkg;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_FILL = 1'b1
  } ic_state_e;

  localparam int IC_OFFSET_W = 2;
  localparam int IC_LINE_W   = 64;
  localparam int IC_ADDR_W   = 16;
  localparam int IC_WORD_W   = 16;

  // Word i of a line lives in bits [16i+15:16i].
  function automatic logic [IC_WORD_W-1:0] ic_word_sel(input logic [IC_LINE_W-1:0] line,
                                                       input logic [IC_OFFSET_W-1:0] off);
    return line[{off, 4'b0000} +: IC_WORD_W];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational
// lookup port, one line-fill write port and a whole-array flush.
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int LINES   = 8,
  parameter int INDEX_W = $clog2(LINES),
  parameter int TAG_W   = IC_ADDR_W - IC_OFFSET_W - INDEX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic [INDEX_W-1:0]   lk_index_i,
  output logic                 lk_valid_o,
  output logic [TAG_W-1:0]     lk_tag_o,
  output logic [IC_LINE_W-1:0] lk_data_o,
  input  logic                 wr_en_i,
  input  logic [INDEX_W-1:0]   wr_index_i,
  input  logic                 wr_valid_i,
  input  logic [TAG_W-1:0]     wr_tag_i,
  input  logic [IC_LINE_W-1:0] wr_data_i
);

  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [IC_LINE_W-1:0] data_q [LINES];

  // Flush beats a coincident fill, so a line filled in that cycle stays invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign lk_valid_o = valid_q[lk_index_i];
  assign lk_tag_o   = tag_q[lk_index_i];
  assign lk_data_o  = data_q[lk_index_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: zero-latency hits, IDLE/FILL
// refill FSM over a hold-until-ready line read, saturating hit/miss counters.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int LINES = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          cpu_addr,
  input  logic                 cpu_rd,
  input  logic                 flush,
  output logic [15:0]          cpu_instr,
  output logic                 cpu_valid,
  output logic                 cpu_stall,
  output logic [13:0]          mem_addr,
  output logic                 mem_rd,
  input  logic [63:0]          mem_data,
  input  logic                 mem_rdy,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt,
  output logic                 dbg_state_o
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = IC_ADDR_W - IC_OFFSET_W - INDEX_W;
  localparam int LADDR_W = IC_ADDR_W - IC_OFFSET_W;

  // Handshake: mem_rd is held high with mem_addr stable for the whole FILL;
  // the first cycle with mem_rd=1 and mem_rdy=1 transfers the line, and
  // mem_rdy is ignored whenever mem_rd=0.
  ic_state_e            state_q;
  logic                 mem_rd_q;
  logic [LADDR_W-1:0]   mem_addr_q;
  logic                 flush_pend_q;
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;

  logic                 lk_valid;
  logic [TAG_W-1:0]     lk_tag;
  logic [IC_LINE_W-1:0] lk_data;
  logic                 hit;
  logic                 miss;
  logic                 fill_done;

  icache_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .lk_index_i (cpu_addr[IC_OFFSET_W +: INDEX_W]),
    .lk_valid_o (lk_valid),
    .lk_tag_o   (lk_tag),
    .lk_data_o  (lk_data),
    .wr_en_i    (fill_done),
    .wr_index_i (mem_addr_q[INDEX_W-1:0]),
    .wr_valid_i (~(flush_pend_q | flush)),
    .wr_tag_i   (mem_addr_q[LADDR_W-1 -: TAG_W]),
    .wr_data_i  (mem_data)
  );

  assign hit = cpu_rd & lk_valid & (lk_tag == cpu_addr[IC_ADDR_W-1 -: TAG_W])
             & (state_q == IC_IDLE) & ~rst;
  assign miss      = cpu_rd & ~hit & (state_q == IC_IDLE) & ~rst;
  assign fill_done = (state_q == IC_FILL) & mem_rdy & ~rst;

  assign cpu_valid   = hit;
  assign cpu_instr   = hit ? ic_word_sel(lk_data, cpu_addr[IC_OFFSET_W-1:0]) : '0;
  assign cpu_stall   = rst | (state_q != IC_IDLE) | (cpu_rd & ~hit);
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign dbg_state_o = state_q;

  // A flush seen at any point of a fill must keep that line invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IC_IDLE;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IC_IDLE: begin
          if (miss) begin
            state_q      <= IC_FILL;
            mem_rd_q     <= 1'b1;
            mem_addr_q   <= cpu_addr[IC_ADDR_W-1:IC_OFFSET_W];
            flush_pend_q <= 1'b0;
          end
        end
        IC_FILL: begin
          if (mem_rdy) begin
            state_q      <= IC_IDLE;
            mem_rd_q     <= 1'b0;
            flush_pend_q <= 1'b0;
          end else if (flush) begin
            flush_pend_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IC_IDLE;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
    if (miss && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl (LINES=8, CNT_W=4): cold miss, spatial hits,
// conflict, flush cases, redirect, reset mid-fill and counter saturation.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        flush;
  logic [15:0] cpu_instr;
  logic        cpu_valid;
  logic        cpu_stall;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic [63:0] mem_data;
  logic        mem_rdy;
  logic [3:0]  hit_cnt;
  logic [3:0]  miss_cnt;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] D1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] D2 = 64'hBBBB_AAAA_9999_8888;
  localparam logic [63:0] D3 = 64'h0D0D_0C0C_0B0B_0A0A;
  localparam logic [63:0] D4 = 64'h1357_2468_ACE0_BDF1;
  localparam logic [63:0] D5 = 64'hFEED_BEEF_CAFE_F00D;

  icache_ctrl #(.LINES(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_rd      (cpu_rd),
    .flush       (flush),
    .cpu_instr   (cpu_instr),
    .cpu_valid   (cpu_valid),
    .cpu_stall   (cpu_stall),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_rdy     (mem_rdy),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Checkers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge, outputs are
  // sampled 1 time unit later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_of(input logic [63:0] line, input logic [1:0] off);
    logic [63:0] sh;
    sh = line >> (16 * off);
    return sh[15:0];
  endfunction

  // Miss at addr in the current cycle, memory answers in the k-th mem_rd
  // cycle, and returns in the re-lookup hit cycle.
  task automatic miss_fill(input logic [15:0] addr, input logic [63:0] data, input int k);
    cpu_rd = 1'b1; cpu_addr = addr; mem_rdy = 1'b0;
    #1;
    chk1("miss_stall", cpu_stall, 1'b1);
    chk1("miss_valid", cpu_valid, 1'b0);
    for (int c = 1; c <= k; c++) begin
      next();
      mem_rdy = (c == k); mem_data = data;
      #1;
      chk1("fill_mem_rd", mem_rd, 1'b1);
      chk16("fill_mem_addr", {2'b00, mem_addr}, {4'h0, addr[15:4]} << 2 | {14'h0, addr[3:2]});
      chk1("fill_stall", cpu_stall, 1'b1);
      chk1("fill_state", dbg_state, 1'b1);
    end
    next();
    mem_rdy = 1'b0;
    #1;
    chk1("refetch_valid", cpu_valid, 1'b1);
    chk16("refetch_instr", cpu_instr, word_of(data, addr[1:0]));
    chk1("refetch_stall", cpu_stall, 1'b0);
    chk1("refetch_mem_rd", mem_rd, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h0040; flush = 1'b0;
    mem_rdy = 1'b0; mem_data = '0;

    // Reset behaviour
    next(); next();
    #1;
    chk1("rst_stall", cpu_stall, 1'b1);
    chk1("rst_valid", cpu_valid, 1'b0);
    chk16("rst_instr", cpu_instr, 16'h0000);
    next();
    rst = 1'b0; cpu_rd = 1'b0;
    #1;
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk16("rst_mem_addr", {2'b00, mem_addr}, 16'h0000);
    chk16("rst_hit_cnt", {12'h0, hit_cnt}, 16'd0);
    chk16("rst_miss_cnt", {12'h0, miss_cnt}, 16'd0);

    // Cold miss: mem_rdy in the 3rd mem_rd cycle, mem_addr 0x0010
    next();
    miss_fill(16'h0040, D1, 3);
    chk16("cold_mem_addr_latched", {2'b00, mem_addr}, 16'h0010);
    next();
    cpu_addr = 16'h0041;
    #1;
    chk16("cold_hit_cnt", {12'h0, hit_cnt}, 16'd1);
    chk16("cold_miss_cnt", {12'h0, miss_cnt}, 16'd1);

    // Spatial hits back-to-back
    chk16("spatial_41", cpu_instr, 16'h2222);
    chk1("spatial_41_stall", cpu_stall, 1'b0);
    next(); cpu_addr = 16'h0042; #1;
    chk16("spatial_42", cpu_instr, 16'h3333);
    chk1("spatial_42_mem_rd", mem_rd, 1'b0);
    next(); cpu_addr = 16'h0043; #1;
    chk16("spatial_43", cpu_instr, 16'h4444);
    chk1("spatial_43_stall", cpu_stall, 1'b0);
    next(); cpu_rd = 1'b0; #1;
    chk16("spatial_hit_cnt", {12'h0, hit_cnt}, 16'd4);

    // Conflict on index 0: 0x0140 then 0x0040 again (minimum penalty fills)
    next();
    miss_fill(16'h0140, D2, 1);
    next();
    miss_fill(16'h0040, D1, 2);
    next(); cpu_rd = 1'b0; #1;
    chk16("conflict_miss_cnt", {12'h0, miss_cnt}, 16'd3);
    chk16("conflict_hit_cnt", {12'h0, hit_cnt}, 16'd6);

    // Flush in IDLE: this cycle still hits, the next lookup misses
    next(); cpu_rd = 1'b1; cpu_addr = 16'h0040; flush = 1'b1; #1;
    chk1("flush_idle_prehit", cpu_valid, 1'b1);
    chk16("flush_idle_preinstr", cpu_instr, 16'h1111);
    next(); flush = 1'b0; #1;
    chk1("flush_idle_miss", cpu_valid, 1'b0);
    miss_fill(16'h0040, D1, 1);

    // Flush during FILL: line stays invalid and misses again
    next(); cpu_addr = 16'h0048; #1;
    chk1("fflush_first_miss", cpu_stall, 1'b1);
    next(); flush = 1'b1; #1;
    next(); flush = 1'b0; mem_rdy = 1'b1; mem_data = D3; #1;
    next(); mem_rdy = 1'b0; #1;
    chk1("fflush_remiss_valid", cpu_valid, 1'b0);
    chk1("fflush_remiss_stall", cpu_stall, 1'b1);
    chk1("fflush_idle_gap", mem_rd, 1'b0);
    next(); mem_rdy = 1'b1; #1;
    chk1("fflush_refill_rd", mem_rd, 1'b1);
    next(); mem_rdy = 1'b0; #1;
    chk1("fflush_final_hit", cpu_valid, 1'b1);
    chk16("fflush_final_instr", cpu_instr, 16'h0A0A);

    // Flush coincident with the mem_rdy cycle
    next(); cpu_addr = 16'h0050; #1;
    next(); mem_rdy = 1'b1; flush = 1'b1; mem_data = D4; #1;
    next(); mem_rdy = 1'b0; flush = 1'b0; #1;
    chk1("cflush_remiss", cpu_valid, 1'b0);
    next(); mem_rdy = 1'b1; #1;
    next(); mem_rdy = 1'b0; #1;
    chk16("cflush_final_instr", cpu_instr, 16'hBDF1);

    // Redirect during FILL: mem_addr holds, new address misses after IDLE
    next(); cpu_addr = 16'h0064; #1;
    next(); cpu_addr = 16'h0080; #1;
    chk16("redir_mem_addr", {2'b00, mem_addr}, 16'h0019);
    next(); mem_rdy = 1'b1; mem_data = D5; #1;
    chk16("redir_mem_addr_held", {2'b00, mem_addr}, 16'h0019);
    next(); mem_rdy = 1'b0; #1;
    chk1("redir_new_miss", cpu_valid, 1'b0);
    chk1("redir_idle_gap", mem_rd, 1'b0);
    next(); #1;
    chk16("redir_new_mem_addr", {2'b00, mem_addr}, 16'h0020);
    mem_rdy = 1'b1; mem_data = D2;
    next(); mem_rdy = 1'b0; #1;
    chk16("redir_new_instr", cpu_instr, 16'h8888);
    next(); cpu_addr = 16'h0064; #1;
    chk16("redir_old_line", cpu_instr, 16'hF00D);

    // Reset mid-FILL
    next(); cpu_addr = 16'h0070; #1;
    chk16("pre_rst_hit_cnt", {12'h0, hit_cnt}, 16'd12);
    chk16("pre_rst_miss_cnt", {12'h0, miss_cnt}, 16'd10);
    next(); cpu_rd = 1'b0; rst = 1'b1; #1;
    chk1("rstfill_mem_rd_before", mem_rd, 1'b1);
    chk1("rstfill_stall", cpu_stall, 1'b1);
    next(); rst = 1'b0; mem_rdy = 1'b1; #1;
    chk1("rstfill_mem_rd", mem_rd, 1'b0);
    chk16("rstfill_hit_cnt", {12'h0, hit_cnt}, 16'd0);
    chk16("rstfill_miss_cnt", {12'h0, miss_cnt}, 16'd0);
    next(); mem_rdy = 1'b0; #1;
    chk1("rstfill_late_rdy", mem_rd, 1'b0);
    cpu_rd = 1'b1; cpu_addr = 16'h0064; #1;
    chk1("rstfill_line_invalid", cpu_valid, 1'b0);

    // Saturation: 20 hits with a 4-bit counter
    miss_fill(16'h0064, D5, 1);
    for (int i = 0; i < 19; i++) next();
    next(); cpu_rd = 1'b0; #1;
    chk16("sat_hit_cnt", {12'h0, hit_cnt}, 16'd15);
    chk16("sat_miss_cnt", {12'h0, miss_cnt}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
